// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state enum, round count, Rcon table
// and the GF(2^8) helpers behind the S-box.
package aes_pkg;

  // AES-128 round count.
  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_t;

  // Rcon for rounds 1..10; the first byte belongs to round 1.
  localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

  // Multiply by x in GF(2^8), modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add form.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Forward S-box: inverse followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Rcon byte for round rnd (1..NR); 0 outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= NR; i++) begin
      if (rnd == 4'(i)) v = RCON_TABLE[8*(NR-i) +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: derives round key rnd from
// round key rnd-1. Purely combinational.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [3:0]   i_rnd,
  output logic [127:0] o_key
);
  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = i_key[127:96];
  assign w_w1 = i_key[95:64];
  assign w_w2 = i_key[63:32];
  assign w_w3 = i_key[31:0];

  // RotWord, SubWord, then Rcon into the top byte.
  assign w_rot  = {w_w3[23:0], w_w3[31:24]};
  assign w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                   sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {rcon(i_rnd), 24'h000000};

  // Word chain: each new word builds on the one just produced.
  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_key = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/aes_round.sv
// Combinational AES round transforms. Byte i of a block is bits
// [127-8i -: 8]; byte i sits at row i%4, column i/4.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] i_blk,
  output logic [127:0] o_blk
);
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      assign o_blk[127-8*gi -: 8] = sbox(i_blk[127-8*gi -: 8]);
    end
  endgenerate
endmodule

// Row r rotates left by r bytes: out(r,c) = in(r,(c+r)%4).
module aes_shift_rows (
  input  logic [127:0] i_blk,
  output logic [127:0] o_blk
);
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
      assign o_blk[127-8*gi -: 8] = i_blk[127-8*SRC -: 8];
    end
  endgenerate
endmodule

// Each column multiplied by the fixed {02,03,01,01} circulant matrix.
module aes_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] i_blk,
  output logic [127:0] o_blk
);
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      assign w_a0 = i_blk[127-32*gi -: 8];
      assign w_a1 = i_blk[119-32*gi -: 8];
      assign w_a2 = i_blk[111-32*gi -: 8];
      assign w_a3 = i_blk[103-32*gi -: 8];
      assign o_blk[127-32*gi -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      assign o_blk[119-32*gi -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      assign o_blk[111-32*gi -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      assign o_blk[103-32*gi -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end
  endgenerate
endmodule

module aes_add_round_key (
  input  logic [127:0] i_blk,
  input  logic [127:0] i_key,
  output logic [127:0] o_blk
);
  assign o_blk = i_blk ^ i_key;
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded
// on the fly. Accept in IDLE, ten RUN cycles, result held in DONE until
// taken. Optional macro AES_ROUND_OUT_EN exposes the round counter on
// round_idx.
module aes_round_ctrl
  import aes_pkg::*;
#(
  // Only 10 (AES-128) is meaningful; the key schedule is 128-bit only.
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher
`ifdef AES_ROUND_OUT_EN
  ,
  output logic [3:0]   round_idx
`endif
);

  aes_state_t   r_fsm, w_fsm_next;
  logic         w_accept;
  logic         w_last;
  logic [127:0] r_blk, r_rkey, r_cipher;
  logic [3:0]   r_rnd;
  logic [127:0] w_next_key, w_sub, w_shift, w_mix, w_pre_ark, w_round_out;

  assign w_last = (r_rnd == 4'(NR));

  aes_key_step u_key_step (
    .i_key (r_rkey),
    .i_rnd (r_rnd),
    .o_key (w_next_key)
  );

  aes_sub_bytes u_sub_bytes (
    .i_blk (r_blk),
    .o_blk (w_sub)
  );

  aes_shift_rows u_shift_rows (
    .i_blk (w_sub),
    .o_blk (w_shift)
  );

  aes_mix_columns u_mix_columns (
    .i_blk (w_shift),
    .o_blk (w_mix)
  );

  // The final round has no MixColumns.
  assign w_pre_ark = w_last ? w_shift : w_mix;

  aes_add_round_key u_add_round_key (
    .i_blk (w_pre_ark),
    .i_key (w_next_key),
    .o_blk (w_round_out)
  );

  // State register for the controller.
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_next;
  end

  // Next state and handshake outputs; outputs depend on state only.
  always_comb begin
    w_fsm_next = r_fsm;
    w_accept   = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept   = 1'b1;
          w_fsm_next = RUN;
        end
      end
      RUN: begin
        if (w_last) w_fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_next = IDLE;
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  // Datapath: load on accept, one round per RUN cycle, capture the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk    <= '0;
      r_rkey   <= '0;
      r_rnd    <= '0;
      r_cipher <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_blk  <= plain ^ key;
            r_rkey <= key;
            r_rnd  <= 4'd1;
          end
        end
        RUN: begin
          r_blk  <= w_round_out;
          r_rkey <= w_next_key;
          if (w_last) r_cipher <= w_round_out;
          else        r_rnd    <= r_rnd + 4'd1;
        end
        DONE: begin
          if (out_ready) r_rnd <= 4'd0;
        end
        default: r_rnd <= 4'd0;
      endcase
    end
  end

  assign cipher = r_cipher;

`ifdef AES_ROUND_OUT_EN
  assign round_idx = r_rnd;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: a transaction-level AES model
// predicts handshake, latency and ciphertext every cycle; directed
// vectors pin known FIPS-197 results.
module tb_aes_round_ctrl;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] plain = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid;
  logic [127:0] cipher;
`ifdef AES_ROUND_OUT_EN
  logic [3:0]   round_idx;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Model state: cycles since accept (-1 when idle), pending and visible result.
  int           m_cnt = -1;
  logic [127:0] m_pend = '0;
  logic [127:0] m_cipher = '0;
  bit           m_live = 1'b0;
  logic [7:0]   sb [256];

  aes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plain     (plain),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cipher    (cipher)
`ifdef AES_ROUND_OUT_EN
    ,
    .round_idx (round_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
    end
  endtask

  // S-box built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] mmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [31:0] msub(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Whole-block AES-128 encryption with a precomputed 44-word schedule.
  function automatic logic [127:0] model_aes(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = msub({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = mmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int i = 0; i < 16; i++) t[i] = s[(i%4) + 4*(((i/4) + (i%4)) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c+0] = mmul(t[4*c], 8'h02) ^ mmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ mmul(t[4*c+1], 8'h02) ^ mmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mmul(t[4*c+2], 8'h02) ^ mmul(t[4*c+3], 8'h03);
          s[4*c+3] = mmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ mmul(t[4*c+3], 8'h02);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Transaction model: accept when idle, result visible 11 cycles later,
  // released by out_ready; reset drops everything.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt    <= -1;
      m_cipher <= '0;
      m_live   <= 1'b1;
    end else if (m_cnt < 0) begin
      if (in_valid) begin
        m_cnt  <= 1;
        m_pend <= model_aes(key, plain);
      end
    end else if (m_cnt < 11) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 10) m_cipher <= m_pend;
    end else if (out_ready) begin
      m_cnt <= -1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check_bit("in_ready", in_ready, m_cnt < 0);
      check_bit("out_valid", out_valid, m_cnt >= 11);
      check_val("cipher", cipher, m_cipher);
`ifdef AES_ROUND_OUT_EN
      check_val("round_idx", 128'(round_idx),
                128'((m_cnt < 0) ? 0 : ((m_cnt > 10) ? 10 : m_cnt)));
`endif
    end
  end

  // Present one block at a negedge in IDLE, wait for the result, hold it
  // for hold cycles, then hand it off. scramble wiggles inputs during RUN.
  task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] exp, input int hold, input bit scramble,
                           input bit valid_at_hs);
    int cnt;
    in_valid = 1'b1;
    key      = k;
    plain    = p;
    for (cnt = 1; cnt <= 40; cnt++) begin
      @(negedge clk);
      if (out_valid) break;
`ifdef AES_ROUND_OUT_EN
      check_val("round_idx_run", 128'(round_idx), 128'(cnt));
`endif
      if (scramble) begin
        in_valid = ~in_valid;
        key      = {$urandom, $urandom, $urandom, $urandom};
        plain    = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_val("latency", 128'(cnt), 128'(11));
    check_val("cipher_vec", cipher, exp);
`ifdef AES_ROUND_OUT_EN
    check_val("round_idx_done", 128'(round_idx), 128'(10));
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      key      = {$urandom, $urandom, $urandom, $urandom};
      plain    = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check_bit("hold_valid", out_valid, 1'b1);
      check_bit("hold_ready", in_ready, 1'b0);
      check_val("hold_cipher", cipher, exp);
    end
    out_ready = 1'b1;
    in_valid  = valid_at_hs;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_bit("idle_ready", in_ready, 1'b1);
    check_bit("idle_valid", out_valid, 1'b0);
    $display("txn %s key=%h plain=%h cipher=%h latency=%0d hold=%0d", tag, k, p, cipher, cnt, hold);
  endtask

  initial begin
    logic [127:0] rk, rp;
    build_sbox();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_val("reset_cipher", cipher, '0);
`ifdef AES_ROUND_OUT_EN
    check_val("reset_round_idx", 128'(round_idx), 128'(0));
`endif

    run_block("fips_c1", K1, P1, C1, 0, 1'b0, 1'b0);
    run_block("fips_b_hold20", K2, P2, C2, 20, 1'b0, 1'b1);
    run_block("c1_scrambled", K1, P1, C1, 2, 1'b1, 1'b0);

    // Abort in the middle of round 5.
    in_valid = 1'b1;
    key      = K1;
    plain    = P1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
`ifdef AES_ROUND_OUT_EN
    check_val("abort_round_idx", 128'(round_idx), 128'(5));
`endif
    rst = 1'b1;
    @(negedge clk);
    check_bit("abort_in_ready", in_ready, 1'b1);
    check_bit("abort_out_valid", out_valid, 1'b0);
    check_val("abort_cipher", cipher, '0);
    rst = 1'b0;
    $display("txn abort_at_round5 in_ready=%b out_valid=%b cipher=%h", in_ready, out_valid, cipher);

    run_block("fips_b_after_abort", K2, P2, C2, 1, 1'b0, 1'b0);

    for (int n = 0; n < 4; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      run_block("random", rk, rp, model_aes(rk, rp), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
